// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave memory bus arbiter with an in-order read-ID FIFO for response routing.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned NR_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_,

  input  logic        m0_cmd_valid,
  input  logic        m0_cmd_wr,
  input  logic        m0_cmd_instr,
  input  logic [31:0] m0_cmd_addr,
  input  logic [31:0] m0_cmd_wdata,
  input  logic [3:0]  m0_cmd_be,
  output logic        m0_cmd_ready,
  output logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,

  input  logic        m1_cmd_valid,
  input  logic        m1_cmd_wr,
  input  logic        m1_cmd_instr,
  input  logic [31:0] m1_cmd_addr,
  input  logic [31:0] m1_cmd_wdata,
  input  logic [3:0]  m1_cmd_be,
  output logic        m1_cmd_ready,
  output logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,

  output logic        s_cmd_valid,
  output logic        s_cmd_wr,
  output logic        s_cmd_instr,
  output logic [31:0] s_cmd_addr,
  output logic [31:0] s_cmd_wdata,
  output logic [3:0]  s_cmd_be,
  input  logic        s_cmd_ready,
  input  logic        s_rsp_ready,
  input  logic [31:0] s_rsp_rdata,

  output logic        err_unexp_rsp
);

  localparam int unsigned PtrW = (NR_OUTSTANDING > 1) ? $clog2(NR_OUTSTANDING) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [NR_OUTSTANDING-1:0] id_mem_q, id_mem_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      lock_q, lock_d;
  logic                      lock_id_q, lock_id_d;
  logic                      err_q, err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                      last_grant_q, last_grant_d;
`endif

  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] elig;
  logic       grant;
  logic       cmd_valid;
  logic       cmd_fire;
  logic       push;
  logic       pop;
  logic       head_id;

  assign fifo_full  = (count_q == CntW'(NR_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // Full FIFO blocks reads using the registered count, so a same-cycle pop does not help.
  always_comb begin
    elig[0] = m0_cmd_valid & ~(~m0_cmd_wr & fifo_full);
    elig[1] = m1_cmd_valid & ~(~m1_cmd_wr & fifo_full);

    if (lock_q) begin
      grant = lock_id_q;
    end else if (elig[0] & elig[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant = ~last_grant_q;
`else
      grant = 1'b0;
`endif
    end else begin
      grant = elig[1] & ~elig[0];
    end

    // Combinational outputs are gated so they read zero throughout reset.
    cmd_valid = reset_ & elig[grant];
  end

  always_comb begin
    if (grant) begin
      s_cmd_wr    = m1_cmd_wr;
      s_cmd_instr = m1_cmd_instr;
      s_cmd_addr  = m1_cmd_addr;
      s_cmd_wdata = m1_cmd_wdata;
      s_cmd_be    = m1_cmd_be;
    end else begin
      s_cmd_wr    = m0_cmd_wr;
      s_cmd_instr = m0_cmd_instr;
      s_cmd_addr  = m0_cmd_addr;
      s_cmd_wdata = m0_cmd_wdata;
      s_cmd_be    = m0_cmd_be;
    end
  end

  assign s_cmd_valid  = cmd_valid;
  assign cmd_fire     = cmd_valid & s_cmd_ready;
  assign m0_cmd_ready = cmd_fire & ~grant;
  assign m1_cmd_ready = cmd_fire & grant;

  assign push    = cmd_fire & ~s_cmd_wr;
  assign pop     = reset_ & s_rsp_ready & ~fifo_empty;
  assign head_id = id_mem_q[rd_ptr_q];

  assign m0_rsp_ready  = pop & ~head_id;
  assign m1_rsp_ready  = pop & head_id;
  assign m0_rsp_rdata  = s_rsp_rdata;
  assign m1_rsp_rdata  = s_rsp_rdata;
  assign err_unexp_rsp = err_q;

  always_comb begin
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      id_mem_d[wr_ptr_q] = grant;
      wr_ptr_d           = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // A stalled command pins the grant until the slave takes it.
  always_comb begin
    lock_d    = cmd_valid & ~s_cmd_ready;
    lock_id_d = lock_d ? grant : lock_id_q;
    err_d     = err_q | (s_rsp_ready & fifo_empty);
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign last_grant_d = cmd_fire ? grant : last_grant_q;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      id_mem_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
      err_q        <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      id_mem_q     <= id_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      err_q        <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
